// File: rtl/quad_emitter.sv
// Quadrature A/B emitter: walks a 2-bit Gray phase toward a signed target position,
// one edge per step, with at least EDGE_CLKS clock cycles between consecutive edges.
//
// state  | meaning
// PH_00  | A=0 B=0
// PH_10  | A=1 B=0 (one forward step past 00)
// PH_11  | A=1 B=1
// PH_01  | A=0 B=1 (one reverse step past 00)
module quad_emitter #(
    parameter int WIDTH     = 32,
    parameter int EDGE_CLKS = 64
) (
    input  logic             CLK,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] target,
    input  logic             target_valid,
    input  logic [WIDTH-1:0] load_value,
    input  logic             load_valid,
    output logic             A,
    output logic             B,
    output logic [WIDTH-1:0] position,
    output logic             busy,
    output logic             arrived
);

    localparam logic [15:0] GAP_MAX = 16'(EDGE_CLKS - 1);

    typedef enum logic [1:0] {
        PH_00 = 2'b00,
        PH_10 = 2'b10,
        PH_11 = 2'b11,
        PH_01 = 2'b01
    } phase_t;

    phase_t           phase, phase_nxt;
    logic [WIDTH-1:0] target_q, target_nxt, position_nxt, position_step;
    logic [15:0]      gap, gap_nxt;
    logic             arrived_nxt;
    logic [WIDTH:0]   diff;
    logic             step, fwd;

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            phase    <= PH_00;
            position <= '0;
            target_q <= '0;
            gap      <= '0;
            arrived  <= 1'b0;
        end else begin
            phase    <= phase_nxt;
            position <= position_nxt;
            target_q <= target_nxt;
            gap      <= gap_nxt;
            arrived  <= arrived_nxt;
        end
    end

    // One extra bit keeps the sign correct across the full signed range.
    always_comb begin
        diff          = {target_q[WIDTH-1], target_q} - {position[WIDTH-1], position};
        fwd           = ~diff[WIDTH];
        step          = enable && (gap == GAP_MAX) && (diff != '0);
        phase_nxt     = phase;
        position_step = position;
        target_nxt    = target_valid ? target : target_q;
        arrived_nxt   = 1'b0;

        if (step) begin
            position_step = fwd ? position + WIDTH'(1) : position - WIDTH'(1);
            unique case (phase)
                PH_00:   phase_nxt = fwd ? PH_10 : PH_01;
                PH_10:   phase_nxt = fwd ? PH_11 : PH_00;
                PH_11:   phase_nxt = fwd ? PH_01 : PH_10;
                PH_01:   phase_nxt = fwd ? PH_00 : PH_11;
                default: phase_nxt = PH_00;
            endcase
        end

        // A preset overrides a coincident step; the gap still restarts as if it had stepped.
        if (load_valid) begin
            phase_nxt    = phase;
            position_nxt = load_value;
        end else begin
            position_nxt = position_step;
            arrived_nxt  = step && (position_step == target_nxt);
        end

        if (step) begin
            gap_nxt = '0;
        end else if (gap == GAP_MAX) begin
            gap_nxt = gap;
        end else begin
            gap_nxt = gap + 16'd1;
        end
    end

    assign A    = phase[1];
    assign B    = phase[0];
    assign busy = (target_q != position);

endmodule

// File: tb/tb_quad_emitter.sv
// Bench for quad_emitter: a position/phase-table model checked every cycle, plus
// directed walks with literal expectations on edge count, spacing, and end state.
module tb_quad_emitter;

    localparam int WIDTH     = 32;
    localparam int EDGE_CLKS = 64;

    logic             CLK = 1'b0;
    logic             reset_n = 1'b0;
    logic             enable = 1'b0;
    logic [WIDTH-1:0] target = '0;
    logic             target_valid = 1'b0;
    logic [WIDTH-1:0] load_value = '0;
    logic             load_valid = 1'b0;
    logic             A, B, busy, arrived;
    logic [WIDTH-1:0] position;

    quad_emitter #(.WIDTH(WIDTH), .EDGE_CLKS(EDGE_CLKS)) dut (
        .CLK(CLK), .reset_n(reset_n), .enable(enable),
        .target(target), .target_valid(target_valid),
        .load_value(load_value), .load_valid(load_valid),
        .A(A), .B(B), .position(position), .busy(busy), .arrived(arrived)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Model: position as a number, phase as an index into the A/B cycle.
    logic [1:0]       seq_tab [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
    logic [WIDTH-1:0] m_pos, m_tgt;
    int               m_ph, m_idle;
    bit               m_arr;

    always @(posedge CLK or negedge reset_n) begin
        longint           d;
        bit               go;
        logic [WIDTH-1:0] np;
        logic [WIDTH-1:0] nt;
        if (!reset_n) begin
            m_pos  <= '0;
            m_tgt  <= '0;
            m_ph   <= 0;
            m_idle <= 0;
            m_arr  <= 1'b0;
        end else begin
            d  = longint'($signed(m_tgt)) - longint'($signed(m_pos));
            go = enable && (m_idle >= EDGE_CLKS - 1) && (d != 0);
            np = (d > 0) ? m_pos + 1 : m_pos - 1;
            nt = target_valid ? target : m_tgt;
            m_tgt  <= nt;
            m_arr  <= 1'b0;
            m_idle <= go ? 0 : m_idle + 1;
            if (load_valid) begin
                m_pos <= load_value;
            end else if (go) begin
                m_pos <= np;
                m_ph  <= (d > 0) ? (m_ph + 1) % 4 : (m_ph + 3) % 4;
                m_arr <= (np == nt);
            end
        end
    end

    always @(negedge CLK) begin
        if (reset_n) begin
            chk("ab", {A, B}, seq_tab[m_ph]);
            chk("position", position, m_pos);
            chk("busy", busy, m_pos != m_tgt);
            chk("arrived", arrived, m_arr);
        end
    end

    logic [1:0] prev_ab = 2'b00;
    int         edge_t[$];
    int         arr_cnt = 0;

    always @(negedge CLK) begin
        cyc++;
        if (reset_n) begin
            if ({A, B} !== prev_ab) begin
                chk("one_bit_per_edge", $countones({A, B} ^ prev_ab), 1);
                edge_t.push_back(cyc);
            end
            if (arrived) arr_cnt++;
        end
        prev_ab = {A, B};
    end

    task automatic step();
        @(negedge CLK);
        #1;
    endtask

    task automatic set_target(input logic [WIDTH-1:0] v);
        target       = v;
        target_valid = 1'b1;
        step();
        target_valid = 1'b0;
    endtask

    task automatic load_and_target(input logic [WIDTH-1:0] lv, input logic [WIDTH-1:0] tv);
        load_value   = lv;
        load_valid   = 1'b1;
        target       = tv;
        target_valid = 1'b1;
        step();
        load_valid   = 1'b0;
        target_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            step();
            n++;
        end
        chk("wait_idle_timeout", n >= budget, 0);
        step();
    endtask

    task automatic wait_pos(input logic [WIDTH-1:0] v, input int budget);
        int n = 0;
        while (position !== v && n < budget) begin
            step();
            n++;
        end
        chk("wait_pos_timeout", n >= budget, 0);
    endtask

    task automatic chk_spacing(input string name);
        for (int i = 1; i < edge_t.size(); i++)
            chk(name, edge_t[i] - edge_t[i-1], EDGE_CLKS);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        enable = 1'b1;
        repeat (3) step();
        chk("rst_ab", {A, B}, 2'b00);
        chk("rst_pos", position, 0);
        chk("rst_busy", busy, 0);
        chk("rst_arrived", arrived, 0);
        reset_n = 1'b1;
        step();

        // Forward walk 0 -> +8
        edge_t.delete(); arr_cnt = 0;
        set_target(32'd8);
        wait_idle(2000);
        chk("t1_edges", edge_t.size(), 8);
        chk_spacing("t1_spacing");
        chk("t1_pos", position, 32'd8);
        chk("t1_ab", {A, B}, 2'b00);
        chk("t1_arrived_count", arr_cnt, 1);
        chk("t1_busy", busy, 0);

        // Reverse walk +8 -> -3; -3 is congruent to +1 mod 4, so phase ends at 10
        edge_t.delete(); arr_cnt = 0;
        set_target(32'hFFFF_FFFD);
        wait_idle(2000);
        chk("t2_edges", edge_t.size(), 11);
        chk_spacing("t2_spacing");
        chk("t2_pos", position, 32'hFFFF_FFFD);
        chk("t2_ab", {A, B}, 2'b10);
        chk("t2_arrived_count", arr_cnt, 1);

        // Reversal mid-walk at +4 while heading to +20
        edge_t.delete(); arr_cnt = 0;
        set_target(32'd20);
        wait_pos(32'd4, 2000);
        set_target(32'd0);
        wait_idle(2000);
        chk("t3_edges", edge_t.size(), 11);
        chk_spacing("t3_spacing");
        chk("t3_pos", position, 32'd0);
        chk("t3_ab", {A, B}, 2'b00);
        chk("t3_arrived_count", arr_cnt, 1);

        // Extremes: preset near max positive, walk to max, then head to min
        edge_t.delete(); arr_cnt = 0;
        load_and_target(32'h7FFF_FFF0, 32'h7FFF_FFFF);
        wait_idle(2000);
        chk("t4_edges", edge_t.size(), 15);
        chk("t4_pos", position, 32'h7FFF_FFFF);
        chk("t4_ab", {A, B}, 2'b01);
        edge_t.delete();
        set_target(32'h8000_0000);
        wait_pos(32'h7FFF_FFF7, 1000);
        chk("t4_rev_edges", edge_t.size(), 8);
        chk("t4_rev_busy", busy, 1);

        // Enable low for 500 cycles mid-walk, then immediate edge on re-enable
        enable = 1'b0;
        edge_t.delete();
        repeat (500) step();
        chk("t5_quiet_edges", edge_t.size(), 0);
        chk("t5_hold_pos", position, 32'h7FFF_FFF7);
        enable = 1'b1;
        step();
        chk("t5_reenable_edges", edge_t.size(), 1);
        chk("t5_reenable_pos", position, 32'h7FFF_FFF6);
        chk("t5_reenable_ab", {A, B}, 2'b11);
        load_and_target(32'd0, 32'd0);
        chk("t5_stop_busy", busy, 0);
        chk("t5_stop_pos", position, 32'd0);

        // Reset pulse while A=B=1 mid-walk
        set_target(32'd6);
        wait_pos(32'd4, 2000);
        chk("t6_pre_ab", {A, B}, 2'b11);
        chk("t6_pre_busy", busy, 1);
        reset_n = 1'b0;
        #1;
        chk("t6_rst_ab", {A, B}, 2'b00);
        chk("t6_rst_pos", position, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_arrived", arrived, 0);
        step();
        reset_n = 1'b1;
        edge_t.delete(); arr_cnt = 0;
        repeat (300) step();
        chk("t6_idle_edges", edge_t.size(), 0);
        chk("t6_idle_pos", position, 0);
        set_target(32'd1);
        wait_idle(500);
        chk("t6_edges", edge_t.size(), 1);
        chk("t6_pos", position, 32'd1);
        chk("t6_ab", {A, B}, 2'b10);
        chk("t6_arrived_count", arr_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
